pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 32, as the width of pc, target_addr_i and new_pc.
REQ-002 The block SHALL take parameter INST_BYTES, default 4, as bytes per instruction; it SHALL be a power of two of at least 1.
REQ-003 The block SHALL take parameter FETCH_N, default 2, as instructions fetched per cycle; the sequential step SHALL be STEP = FETCH_N*INST_BYTES.
REQ-004 The block SHALL take parameter RESET_VEC, default 0, as the pc value held while ce is disabled; it SHALL be INST_BYTES-aligned.
REQ-005 The block SHALL take parameter STALL_W, default 6, as the width of stall.
REQ-006 Port clk, input, 1 bit: the only clock; all state SHALL update on its rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port stall, input, STALL_W bits: pipeline stall vector; only stall[0] is used, and 1 means hold pc.
REQ-009 Port branch_flag_i, input, 1 bit: branch redirect request.
REQ-010 Port target_addr_i, input, ADDR_W bits: branch target.
REQ-011 Port flush, input, 1 bit: exception redirect request.
REQ-012 Port new_pc, input, ADDR_W bits: exception handler address.
REQ-013 Port pc, output reg, ADDR_W bits: current fetch address.
REQ-014 Port ce, output reg, 1 bit: fetch chip enable.
REQ-015 Port redirect_o, output reg, 1 bit: 1-cycle pulse asserted when pc was loaded from a non-sequential source on the preceding edge.
REQ-016 Port misalign_o, output reg, 1 bit: 1-cycle pulse asserted when the loaded redirect address had nonzero low log2(INST_BYTES) bits.

Function
REQ-017 The block SHALL hold these states: ce, pc, a pending-redirect register (pend_v, pend_addr), redirect_o and misalign_o.
REQ-018 While ce=0, the block SHALL hold pc=RESET_VEC, pend_v=0, redirect_o=0 and misalign_o=0, and it SHALL ignore flush, branch_flag_i and stall.
REQ-019 ce SHALL rise to 1 on the first clk rising edge after rst deasserts; pc SHALL first advance on the following edge.
REQ-020 When ce=1, the block SHALL update pc each edge by strict priority:
  (a) flush=1: pc <= new_pc, pend_v <= 0; this applies regardless of stall.
  (b) else stall[0]=0 and branch_flag_i=1: pc <= target_addr_i, pend_v <= 0.
  (c) else stall[0]=0 and pend_v=1: pc <= pend_addr, pend_v <= 0.
  (d) else stall[0]=0: pc <= pc + STEP.
  (e) else (stalled): pc holds; if branch_flag_i=1, then pend_v <= 1 and pend_addr <= target_addr_i, with the newest request overwriting any earlier one.
REQ-021 Every redirect load (a, b, c) SHALL clear the low log2(INST_BYTES) bits of the loaded address, set redirect_o=1 for exactly the next cycle, and set misalign_o=1 for the next cycle when those bits were nonzero.
REQ-022 The pc+STEP addition SHALL be ADDR_W bits wide and wrap modulo 2^ADDR_W with no flag.
REQ-023 redirect_o and misalign_o SHALL be 0 in every cycle not covered by REQ-021, including stalled cycles.
REQ-024 A redirect captured during a stall SHALL never be lost unless superseded by flush, by a newer branch or by a direct branch at release.
REQ-025 A stall with no branch SHALL leave pc, pend_v and pend_addr unchanged.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force ce=0, pc=RESET_VEC, pend_v=0, pend_addr=0, redirect_o=0 and misalign_o=0.
REQ-027 rst asserted mid-operation, including with pend_v=1, SHALL discard all pending state; the sequence after release SHALL be identical to power-up.

Verification
REQ-028 Defaults with rst released at cycle 0 -> ce=1 after edge 1; pc SHALL read 0, 8, 16, 24 on the following edges.
REQ-029 Branch with target 0x100 while stall[0]=1 for 3 cycles, branch_flag_i deasserted before release -> pc holds during the stall; on the release edge pc=0x100 and redirect_o=1 for 1 cycle; then pc=0x108.
REQ-030 flush=1 with new_pc=0x80, simultaneous with branch_flag_i=1, target 0x200 and stall[0]=1 -> pc=0x80 on the next edge and pend_v=0; no later jump to 0x200.
REQ-031 Branch to 0x103 with INST_BYTES=4 -> pc=0x100, misalign_o=1 and redirect_o=1 for exactly 1 cycle.
REQ-032 ADDR_W=8 with pc=0xFC and STEP=8 -> the next pc is 0x04 with no flag.
REQ-033 rst pulsed asynchronously between edges while pend_v=1 -> ce=0 and pc=RESET_VEC immediately; after release the captured target is never fetched.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential stepping plus prioritised
// flush / branch / pending-branch redirects with a stall-tolerant capture slot.
module pc_gen #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INST_BYTES = 4,
  parameter int unsigned       FETCH_N    = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC  = {ADDR_W{1'b0}},
  parameter int unsigned       STALL_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  target_addr_i,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               redirect_o,
  output logic               misalign_o
);

  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(FETCH_N * INST_BYTES);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
    return addr & ~LOW_MASK;
  endfunction

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return |(addr & LOW_MASK);
  endfunction

  logic              pend_v_r;
  logic [ADDR_W-1:0] pend_addr_r;
  logic              load_s;
  logic [ADDR_W-1:0] src_addr_s;
  logic [ADDR_W-1:0] seq_pc_s;
  logic              unused_stall_s;

  // Only bit 0 of the stall vector affects the fetch stage.
  assign unused_stall_s = ^stall;
  assign seq_pc_s       = pc + STEP;

  // Select the redirect source by priority: flush, direct branch, pending branch.
  always_comb begin
    load_s     = 1'b0;
    src_addr_s = {ADDR_W{1'b0}};
    if (flush) begin
      load_s     = 1'b1;
      src_addr_s = new_pc;
    end else if (!stall[0] && branch_flag_i) begin
      load_s     = 1'b1;
      src_addr_s = target_addr_i;
    end else if (!stall[0] && pend_v_r) begin
      load_s     = 1'b1;
      src_addr_s = pend_addr_r;
    end else begin
      load_s     = 1'b0;
      src_addr_s = {ADDR_W{1'b0}};
    end
  end

  // PC, enable, pending-branch slot and redirect pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce          <= 1'b0;
      pc          <= RESET_VEC;
      pend_v_r    <= 1'b0;
      pend_addr_r <= {ADDR_W{1'b0}};
      redirect_o  <= 1'b0;
      misalign_o  <= 1'b0;
    end else if (!ce) begin
      ce         <= 1'b1;
      pc         <= RESET_VEC;
      pend_v_r   <= 1'b0;
      redirect_o <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      redirect_o <= load_s;
      misalign_o <= load_s & is_misaligned(src_addr_s);
      if (load_s) begin
        pc       <= align_addr(src_addr_s);
        pend_v_r <= 1'b0;
      end else if (stall[0]) begin
        // Newest branch seen while stalled replaces any earlier capture.
        if (branch_flag_i) begin
          pend_v_r    <= 1'b1;
          pend_addr_r <= target_addr_i;
        end
      end else begin
        pc <= seq_pc_s;
      end
    end
  end

endmodule
